// File: rtl/output_port_scheduler_pkg.sv
// Shared flit-id encodings, port indices and scheduler state type for the 5-port router.
// Port order everywhere is {S,W,E,N,L}, with L at bit 0.
package output_port_scheduler_pkg;

    localparam logic [2:0] FLIT_HEADER = 3'd1;
    localparam logic [2:0] FLIT_BODY   = 3'd2;
    localparam logic [2:0] FLIT_TAIL   = 3'd3;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Round-robin successor of a port index, wrapping S back to L.
    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p >= 3'(PORT_S)) ? 3'(PORT_L) : p + 3'd1;
    endfunction

endpackage

// File: rtl/output_port_scheduler_rr_pick.sv
// rr_pick5: combinational 5-way round-robin picker, one-hot result; first requester at or after rr_ptr.
// Pointer values 5..7 are treated as 0.
module rr_pick5 (
    input  logic [4:0] req,
    input  logic [2:0] rr_ptr,
    output logic [4:0] pick
);

    logic [2:0] ptr;
    logic [9:0] rot_req;
    logic [4:0] low;
    logic [9:0] back;

    assign ptr = (rr_ptr > 3'd4) ? 3'd0 : rr_ptr;

    // Rotate so rr_ptr lands at bit 0, isolate the lowest set bit, rotate back.
    assign rot_req = {req, req} >> ptr;
    assign low     = rot_req[4:0] & (~rot_req[4:0] + 5'd1);
    assign back    = {low, low} << ptr;
    assign pick    = back[9:5];

endmodule

// File: rtl/output_port_scheduler.sv
// Wormhole output-port scheduler: round-robin grant held HEADER..TAIL, flits gated by downstream credits.
// Grant one cycle after request; xfer is combinational and stalls at zero credits. Watchdog: ARB_WATCHDOG_EN.
module output_port_scheduler
    import output_port_scheduler_pkg::*;
#(
    parameter int CREDITS    = 4,
    parameter int CW         = 3,
    parameter int WDOG_LIMIT = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req,
    input  logic [14:0]   flit_id,
    input  logic          credit_ret,
    output logic [4:0]    grant,
    output logic          xfer,
    output logic [CW-1:0] credits,
    output logic          busy,
    output logic          cred_err,
    output logic          wdog_err
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    state_t     state;
    logic [2:0] rr_ptr;
    logic [4:0] pick;
    logic [2:0] g_idx;
    logic       req_g;
    logic [2:0] flit_g;
    logic       tail_xfer;
    logic       wdog_fire;
    logic       release_port;

    rr_pick5 u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick)
    );

    always_comb begin
        g_idx  = 3'd0;
        req_g  = 1'b0;
        flit_g = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (grant[i]) begin
                g_idx  = 3'(i);
                req_g  = req[i];
                flit_g = flit_id[i*3 +: 3];
            end
        end
    end

    // No credit_ret term here: a returned credit is only usable from the next cycle.
    assign xfer      = (state == LOCKED) && req_g && (credits != '0);
    assign tail_xfer = xfer && (flit_g == FLIT_TAIL);

`ifdef ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_LIMIT + 1);
    logic [WW-1:0] wdog_cnt;

    assign wdog_fire = (state == LOCKED) && !xfer && (wdog_cnt == WW'(WDOG_LIMIT - 1));

    // Held at zero through IDLE, so every LOCKED entry starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state == IDLE || xfer)
                wdog_cnt <= '0;
            else
                wdog_cnt <= wdog_cnt + WW'(1);
            if (wdog_fire)
                wdog_err <= 1'b1;
        end
    end
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = (WDOG_LIMIT != 0);
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    assign release_port = tail_xfer || wdog_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        state <= LOCKED;
                        grant <= pick;
                        busy  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (release_port) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_port(g_idx);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits  <= CRED_MAX;
            cred_err <= 1'b0;
        end else if (xfer && !credit_ret) begin
            credits <= credits - CW'(1);
        end else if (!xfer && credit_ret) begin
            if (credits == CRED_MAX)
                cred_err <= 1'b1;
            else
                credits <= credits + CW'(1);
        end
    end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: packet-level reference model checked every cycle plus directed literal checks.
module tb_output_port_scheduler;
    import output_port_scheduler_pkg::*;

    localparam int CREDITS    = 4;
    localparam int CW         = 3;
    localparam int WDOG_LIMIT = 8;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic [4:0]    req        = '0;
    logic [14:0]   flit_id    = '0;
    logic          credit_ret = 1'b0;
    logic [4:0]    grant;
    logic          xfer;
    logic [CW-1:0] credits;
    logic          busy;
    logic          cred_err;
    logic          wdog_err;

    int total = 0;
    int bad   = 0;

    output_port_scheduler #(
        .CREDITS    (CREDITS),
        .CW         (CW),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .flit_id    (flit_id),
        .credit_ret (credit_ret),
        .grant      (grant),
        .xfer       (xfer),
        .credits    (credits),
        .busy       (busy),
        .cred_err   (cred_err),
        .wdog_err   (wdog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: which input owns the port, whose turn is next, and how many slots remain downstream.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cred  = CREDITS;
    int m_stall = 0;
    bit m_cerr  = 1'b0;
    bit m_werr  = 1'b0;

    function automatic bit m_xfer();
        return (m_owner >= 0) && req[m_owner] && (m_cred > 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cred  = CREDITS;
            m_stall = 0;
            m_cerr  = 1'b0;
            m_werr  = 1'b0;
        end else begin
            bit mx;
            mx = m_xfer();
            if (m_owner < 0) begin
                if (req != '0) begin
                    for (int k = 0; k < 5; k++)
                        if (m_owner < 0 && req[(m_ptr + k) % 5]) m_owner = (m_ptr + k) % 5;
                    m_stall = 0;
                end
            end else if (mx && flit_id[m_owner*3 +: 3] == FLIT_TAIL) begin
                m_ptr   = (m_owner + 1) % 5;
                m_owner = -1;
            end else if (mx) begin
                m_stall = 0;
            end else begin
`ifdef ARB_WATCHDOG_EN
                if (m_stall == WDOG_LIMIT - 1) begin
                    m_ptr   = (m_owner + 1) % 5;
                    m_owner = -1;
                    m_werr  = 1'b1;
                end else
`endif
                m_stall++;
            end
            m_cred = m_cred - int'(mx) + int'(credit_ret);
            if (m_cred > CREDITS) begin
                m_cred = CREDITS;
                m_cerr = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("cyc_busy", 32'(busy), 32'(m_owner >= 0));
        chk("cyc_xfer", 32'(xfer), 32'(m_xfer()));
        chk("cyc_credits", 32'(credits), 32'(m_cred));
        chk("cyc_cred_err", 32'(cred_err), 32'(m_cerr));
        chk("cyc_wdog_err", 32'(wdog_err), 32'(m_werr));
    end

    // Source side: each input streams HEADER, BODY..., TAIL as its flits are taken.
    int pos  [5];
    int plen [5];

    function automatic logic [2:0] src_fid(input int i);
        if (pos[i] == plen[i] - 1) return FLIT_TAIL;
        if (pos[i] == 0)           return FLIT_HEADER;
        return FLIT_BODY;
    endfunction

    task automatic drive(input logic [4:0] r, input logic c);
        logic [14:0] f;
        f = '0;
        for (int i = 0; i < 5; i++) f[i*3 +: 3] = src_fid(i);
        req        = r;
        flit_id    = f;
        credit_ret = c;
        #1;
    endtask

    task automatic tick();
        if (xfer) begin
            for (int i = 0; i < 5; i++) begin
                if (grant[i]) begin
                    pos[i]++;
                    if (pos[i] == plen[i]) pos[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        flit_id    = '0;
        credit_ret = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pos[i]  = 0;
            plen[i] = 3;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [4:0] exp_g2 [10];

    initial begin
        exp_g2 = '{5'b00001, 5'b00001, 5'b00000, 5'b00100, 5'b00100,
                   5'b00000, 5'b10000, 5'b10000, 5'b00000, 5'b00001};

        // 1: three-flit packet from L
        do_reset();
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_credits", 32'(credits), 32'd4);
        chk("reset_busy", 32'(busy), 32'd0);
        plen[PORT_L] = 3;
        drive(5'b00001, 1'b0);
        chk("t1_no_early_xfer", 32'(xfer), 32'd0);
        tick();
        chk("t1_grant", 32'(grant), 32'b00001);
        for (int k = 0; k < 3; k++) begin
            drive(5'b00001, 1'b0);
            chk("t1_xfer", 32'(xfer), 32'd1);
            tick();
        end
        chk("t1_release", 32'(grant), 32'd0);
        chk("t1_credits", 32'(credits), 32'd1);
        chk("t1_model_ptr", 32'(m_ptr), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(5'b00000, 1'b1);
            tick();
        end
        chk("t1_refill", 32'(credits), 32'd4);

        // 2: L, E, S requesting together, two-flit packets, credit back every cycle
        do_reset();
        for (int i = 0; i < 5; i++) plen[i] = 2;
        for (int k = 0; k < 10; k++) begin
            drive(5'b10101, 1'b1);
            tick();
            chk($sformatf("t2_grant_%0d", k), 32'(grant), 32'(exp_g2[k]));
        end
        chk("t2_cred_err", 32'(cred_err), 32'd1);
        drive(5'b00000, 1'b0);

        // 3: six-flit packet from N runs out of credits
        do_reset();
        plen[PORT_N] = 6;
        drive(5'b00010, 1'b0);
        tick();
        chk("t3_grant", 32'(grant), 32'b00010);
        for (int k = 0; k < 4; k++) begin
            drive(5'b00010, 1'b0);
            chk("t3_xfer", 32'(xfer), 32'd1);
            tick();
        end
        chk("t3_empty", 32'(credits), 32'd0);
        for (int k = 0; k < 2; k++) begin
            drive(5'b00010, 1'b0);
            chk("t3_stall_xfer", 32'(xfer), 32'd0);
            chk("t3_stall_grant", 32'(grant), 32'b00010);
            tick();
        end
        drive(5'b00010, 1'b1);
        chk("t3_no_ret_path", 32'(xfer), 32'd0);
        tick();
        chk("t3_one_credit", 32'(credits), 32'd1);
        drive(5'b00010, 1'b0);
        chk("t3_one_xfer", 32'(xfer), 32'd1);
        tick();
        drive(5'b00010, 1'b0);
        chk("t3_stall_again", 32'(xfer), 32'd0);
        tick();
        drive(5'b00010, 1'b1);
        tick();
        drive(5'b00010, 1'b0);
        chk("t3_tail_xfer", 32'(xfer), 32'd1);
        tick();
        chk("t3_release", 32'(grant), 32'd0);
        drive(5'b00000, 1'b0);

        // 4: xfer and credit_ret together; credit_ret at full
        do_reset();
        plen[PORT_E] = 4;
        drive(5'b00100, 1'b0); tick();
        drive(5'b00100, 1'b0); tick();
        drive(5'b00100, 1'b0); tick();
        chk("t4_two", 32'(credits), 32'd2);
        drive(5'b00100, 1'b1);
        chk("t4_xfer", 32'(xfer), 32'd1);
        tick();
        chk("t4_same_cycle", 32'(credits), 32'd2);
        drive(5'b00100, 1'b0); tick();
        chk("t4_after_tail", 32'(credits), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(5'b00000, 1'b1);
            tick();
        end
        chk("t4_full", 32'(credits), 32'd4);
        chk("t4_no_err_yet", 32'(cred_err), 32'd0);
        drive(5'b00000, 1'b1); tick();
        chk("t4_saturate", 32'(credits), 32'd4);
        chk("t4_cred_err", 32'(cred_err), 32'd1);
        drive(5'b00000, 1'b0);

        // 5: asynchronous reset mid-packet from W
        do_reset();
        plen[PORT_W] = 4;
        drive(5'b01000, 1'b0); tick();
        drive(5'b01000, 1'b0); tick();
        drive(5'b01000, 1'b0);
        chk("t5_mid_xfer", 32'(xfer), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(grant), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_xfer", 32'(xfer), 32'd0);
        chk("t5_async_credits", 32'(credits), 32'd4);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) pos[i] = 0;
        tick();
        chk("t5_after_credits", 32'(credits), 32'd4);

        // 6: S stalls after its HEADER
        do_reset();
        plen[PORT_S] = 3;
        drive(5'b10000, 1'b0); tick();
        drive(5'b10000, 1'b0); tick();
        for (int k = 0; k < 8; k++) begin
            drive(5'b00000, 1'b0);
            tick();
`ifdef ARB_WATCHDOG_EN
            chk($sformatf("t6_hold_%0d", k), 32'(grant), (k == 7) ? 32'd0 : 32'b10000);
`else
            chk($sformatf("t6_hold_%0d", k), 32'(grant), 32'b10000);
`endif
        end
`ifdef ARB_WATCHDOG_EN
        chk("t6_wdog_err", 32'(wdog_err), 32'd1);
`else
        chk("t6_wdog_err", 32'(wdog_err), 32'd0);
        drive(5'b10000, 1'b0); tick();
        drive(5'b10000, 1'b0); tick();
        chk("t6_release", 32'(grant), 32'd0);
`endif
        drive(5'b00000, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
